// File: rtl/starship_controller.sv
// Starship sprite/motion block: position, shield FSM and registered 12-bit RGB pixel stream.
// Optional macro STARSHIP_BG_TRACK_EN makes the background colour follow the last held direction button.
module starship_controller #(
   parameter int H_ORIGIN     = 144,
   parameter int V_ORIGIN     = 35,
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int SHIP_W       = 64,
   parameter int SHIP_H       = 48,
   parameter int SHIELD_W     = 8,
   parameter int STEP         = 2,
   parameter int MOVE_DIV     = 500000,
   parameter int WRAP         = 1,
   parameter int SHIELD_TICKS = 120,
   parameter int COOL_TICKS   = 60,
   parameter int START_X      = 288,
   parameter int START_Y      = 216
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bright,
   input  logic [9:0]  hCount,
   input  logic [9:0]  vCount,
   input  logic        up,
   input  logic        down,
   input  logic        left,
   input  logic        right,
   input  logic        shield_btn,
   output logic [11:0] rgb,
   output logic [9:0]  xpos,
   output logic [9:0]  ypos,
   output logic        shield_on,
   output logic        move_tick
);
   // state    | meaning
   // IDLE     | shield off, waiting for a press edge
   // ACTIVE   | shield up, counting SHIELD_TICKS move ticks
   // COOLDOWN | shield down, counting COOL_TICKS move ticks, presses ignored
   typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;

   localparam int DIV_W   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam int CNT_MAX = (SHIELD_TICKS > COOL_TICKS) ? SHIELD_TICKS : COOL_TICKS;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MOVE_DIV - 1);
   localparam logic [CNT_W-1:0] SHIELD_LD = CNT_W'(SHIELD_TICKS);
   localparam logic [CNT_W-1:0] COOL_LD   = CNT_W'(COOL_TICKS);

   localparam logic [9:0]        XMAX_U = 10'(H_ACTIVE - SHIP_W);
   localparam logic [9:0]        YMAX_U = 10'(V_ACTIVE - SHIP_H);
   localparam logic signed [10:0] XMAX_S = 11'(H_ACTIVE - SHIP_W);
   localparam logic signed [10:0] YMAX_S = 11'(V_ACTIVE - SHIP_H);
   localparam logic signed [10:0] STEP_S = 11'(STEP);
   localparam logic signed [10:0] H_ORG_S = 11'(H_ORIGIN);
   localparam logic signed [10:0] V_ORG_S = 11'(V_ORIGIN);
   localparam logic signed [10:0] SW_S    = 11'(SHIP_W);
   localparam logic signed [10:0] SH_S    = 11'(SHIP_H);
   localparam logic signed [10:0] SHW_S   = 11'(SHIELD_W);
   localparam logic signed [10:0] WIN_X0  = 11'(SHIP_W / 4);
   localparam logic signed [10:0] WIN_X1  = 11'(3 * SHIP_W / 4);
   localparam logic signed [10:0] WIN_Y1  = 11'(SHIP_H / 3);

   logic [DIV_W-1:0] div_q;
   logic             tick_q;
   logic [9:0]       xpos_q, xpos_d, ypos_q, ypos_d;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             btn_q, shield_q;
   logic [11:0]      rgb_q, rgb_d, bg_color;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else if (div_q == DIV_LAST) begin
         div_q  <= '0;
         tick_q <= 1'b1;
      end else begin
         div_q  <= div_q + DIV_W'(1);
         tick_q <= 1'b0;
      end
   end

   // 11-bit signed arithmetic so stepping past either edge is visible as overflow or a negative value
   logic signed [10:0] x_inc, x_dec, y_inc, y_dec;
   always_comb begin
      x_inc  = signed'({1'b0, xpos_q}) + STEP_S;
      x_dec  = signed'({1'b0, xpos_q}) - STEP_S;
      y_inc  = signed'({1'b0, ypos_q}) + STEP_S;
      y_dec  = signed'({1'b0, ypos_q}) - STEP_S;
      xpos_d = xpos_q;
      ypos_d = ypos_q;
      if (tick_q) begin
         if (right)
            xpos_d = (x_inc > XMAX_S) ? ((WRAP != 0) ? 10'd0 : XMAX_U) : x_inc[9:0];
         else if (left)
            xpos_d = (x_dec < 0) ? ((WRAP != 0) ? XMAX_U : 10'd0) : x_dec[9:0];
         else if (up)
            ypos_d = (y_dec < 0) ? ((WRAP != 0) ? YMAX_U : 10'd0) : y_dec[9:0];
         else if (down)
            ypos_d = (y_inc > YMAX_S) ? ((WRAP != 0) ? 10'd0 : YMAX_U) : y_inc[9:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xpos_q <= 10'(START_X);
         ypos_q <= 10'(START_Y);
      end else begin
         xpos_q <= xpos_d;
         ypos_q <= ypos_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         btn_q    <= 1'b0;
         shield_q <= 1'b0;
      end else begin
         btn_q <= shield_btn;
         case (state_q)
            IDLE: begin
               if (shield_btn && !btn_q) begin
                  state_q  <= ACTIVE;
                  cnt_q    <= SHIELD_LD;
                  shield_q <= 1'b1;
               end
            end
            ACTIVE: begin
               if (tick_q) begin
                  if (cnt_q <= CNT_W'(1)) begin
                     state_q  <= COOLDOWN;
                     cnt_q    <= COOL_LD;
                     shield_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            COOLDOWN: begin
               if (tick_q) begin
                  if (cnt_q <= CNT_W'(1)) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            default: begin
               state_q  <= IDLE;
               shield_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef STARSHIP_BG_TRACK_EN
   logic [11:0] bg_q;
   always_ff @(posedge clk) begin
      if (rst)        bg_q <= 12'hFFF;
      else if (right) bg_q <= 12'hFF0;
      else if (left)  bg_q <= 12'h0FF;
      else if (down)  bg_q <= 12'h0F0;
      else if (up)    bg_q <= 12'h00F;
   end
   assign bg_color = bg_q;
`else
   assign bg_color = 12'h08A;
`endif

   // Signed screen coordinates keep off-screen shield bars from aliasing onto visible pixels
   logic signed [10:0] sx, sy, xs, ys;
   logic               in_rows, shield_px, win_px, body_px;
   always_comb begin
      sx        = signed'({1'b0, hCount}) - H_ORG_S;
      sy        = signed'({1'b0, vCount}) - V_ORG_S;
      xs        = signed'({1'b0, xpos_q});
      ys        = signed'({1'b0, ypos_q});
      in_rows   = (sy >= ys) && (sy < ys + SH_S);
      shield_px = shield_q && in_rows &&
                  (((sx >= xs - SHW_S) && (sx < xs)) ||
                   ((sx >= xs + SW_S) && (sx < xs + SW_S + SHW_S)));
      win_px    = (sx >= xs + WIN_X0) && (sx < xs + WIN_X1) && (sy >= ys) && (sy < ys + WIN_Y1);
      body_px   = in_rows && (sx >= xs) && (sx < xs + SW_S);
      if (!bright)        rgb_d = 12'h000;
      else if (shield_px) rgb_d = 12'hFEE;
      else if (win_px)    rgb_d = 12'h9DF;
      else if (body_px)   rgb_d = 12'hCCC;
      else                rgb_d = bg_color;
   end

   always_ff @(posedge clk) begin
      if (rst) rgb_q <= 12'h000;
      else     rgb_q <= rgb_d;
   end

   assign rgb       = rgb_q;
   assign xpos      = xpos_q;
   assign ypos      = ypos_q;
   assign shield_on = shield_q;
   assign move_tick = tick_q;

endmodule

// File: tb/tb_starship_controller.sv
// Three starship_controller builds (slow-tick wrap, fast wrap, fast clamp) on shared stimulus,
// checked every cycle against a tick-count model plus hand-computed literals.
module tb_starship_controller;
   logic        clk, rst, bright, up, down, left, right, shield_btn;
   logic [9:0]  hCount, vCount;
   logic [2:0][11:0] ro;
   logic [2:0][9:0]  xo, yo;
   logic [2:0]       so, to;

   int n_checks = 0;
   int n_errors = 0;

   localparam int S_T = 3;
   localparam int C_T = 2;
`ifdef STARSHIP_BG_TRACK_EN
   localparam logic [11:0] BG_RST  = 12'hFFF;
   localparam logic [11:0] BG_LEFT = 12'h0FF;
`else
   localparam logic [11:0] BG_RST  = 12'h08A;
   localparam logic [11:0] BG_LEFT = 12'h08A;
`endif

   for (genvar g = 0; g < 3; g++) begin : g_dut
      starship_controller #(
         .MOVE_DIV(g == 0 ? 4 : 1), .WRAP(g == 2 ? 0 : 1),
         .SHIELD_TICKS(S_T), .COOL_TICKS(C_T)
      ) u_dut (
         .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
         .up(up), .down(down), .left(left), .right(right), .shield_btn(shield_btn),
         .rgb(ro[g]), .xpos(xo[g]), .ypos(yo[g]), .shield_on(so[g]), .move_tick(to[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: position as plain integers, shield phase derived from ticks elapsed since the press
   int          mx[3], my[3], mn[3], tot[3], st[3];
   bit          eng[3], mtk[3];
   logic [11:0] mrgb[3];
   logic [11:0] mbg;
   bit          mprev, m_valid;

   function automatic int div_of(int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic int lim(int v, int vmax, bit wrap);
      if (v > vmax) return wrap ? 0 : vmax;
      if (v < 0)    return wrap ? vmax : 0;
      return v;
   endfunction

   function automatic logic [11:0] m_pix(int x, int y, bit son, logic [11:0] bg);
      int sx = int'(hCount) - 144;
      int sy = int'(vCount) - 35;
      bit rows = (sy >= y) && (sy < y + 48);
      if (!bright) return 12'h000;
      if (son && rows && ((sx >= x - 8 && sx < x) || (sx >= x + 64 && sx < x + 72))) return 12'hFEE;
      if (sx >= x + 16 && sx < x + 48 && sy >= y && sy < y + 16) return 12'h9DF;
      if (rows && sx >= x && sx < x + 64) return 12'hCCC;
      return bg;
   endfunction

   task automatic m_step();
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            mx[i] = 288; my[i] = 216; mn[i] = 0; tot[i] = 0; st[i] = 0;
            eng[i] = 0; mtk[i] = 0; mrgb[i] = 12'h000;
         end
         mbg = BG_RST; mprev = 0; m_valid = 1;
      end else begin
         for (int i = 0; i < 3; i++) begin
            bit idle = !eng[i] || (tot[i] - st[i] >= S_T + C_T);
            bit son  = eng[i] && (tot[i] - st[i] < S_T);
            mrgb[i] = m_pix(mx[i], my[i], son, mbg);
            if (mtk[i]) begin
               if (right)     mx[i] = lim(mx[i] + 2, 576, i != 2);
               else if (left) mx[i] = lim(mx[i] - 2, 576, i != 2);
               else if (up)   my[i] = lim(my[i] - 2, 432, i != 2);
               else if (down) my[i] = lim(my[i] + 2, 432, i != 2);
               tot[i]++;
            end
            if (idle && shield_btn && !mprev) begin
               eng[i] = 1; st[i] = tot[i];
            end
            mn[i]++;
            mtk[i] = (mn[i] % div_of(i)) == 0;
         end
         mprev = shield_btn;
`ifdef STARSHIP_BG_TRACK_EN
         if (right)     mbg = 12'hFF0;
         else if (left) mbg = 12'h0FF;
         else if (down) mbg = 12'h0F0;
         else if (up)   mbg = 12'h00F;
`endif
      end
   endtask

   initial begin
      m_valid = 0;
      forever begin
         @(posedge clk);
         m_step();
         @(negedge clk);
         if (m_valid) begin
            for (int i = 0; i < 3; i++) begin
               chk($sformatf("xpos[%0d]", i), int'(xo[i]), mx[i]);
               chk($sformatf("ypos[%0d]", i), int'(yo[i]), my[i]);
               chk($sformatf("shield_on[%0d]", i), int'(so[i]), int'(eng[i] && (tot[i] - st[i] < S_T)));
               chk($sformatf("move_tick[%0d]", i), int'(to[i]), int'(mtk[i]));
               chk($sformatf("rgb[%0d]", i), int'(ro[i]), int'(mrgb[i]));
            end
         end
      end
   end

   logic [7:0] tp;
   logic [6:0] sp;

   initial begin
      rst = 1; bright = 0; hCount = '0; vCount = '0;
      up = 0; down = 0; left = 0; right = 0; shield_btn = 0;
      @(negedge clk); @(negedge clk);
      chk("reset_xpos", int'(xo[0]), 288);
      chk("reset_ypos", int'(yo[0]), 216);
      chk("reset_rgb", int'(ro[0]), 0);
      chk("reset_shield", int'(so[0]), 0);
      rst = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         tp[k-1] = to[0];
      end
      chk("tick_every_4th", int'(tp), 8'h88);

      shield_btn = 1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         sp[k-1] = so[1];
         case (k)
            1, 5: shield_btn = 0;
            4, 6: shield_btn = 1;
            7: begin
               shield_btn = 0; bright = 1; hCount = 10'(144 + 284); vCount = 10'(35 + 220);
            end
            default: ;
         endcase
      end
      chk("shield_sequence", int'(sp), 7'b1000111);

      @(negedge clk); chk("pix_shield", int'(ro[1]), 12'hFEE);
      hCount = 10'(144 + 310);
      @(negedge clk); chk("pix_window", int'(ro[1]), 12'h9DF);
      hCount = 10'(144 + 300); vCount = 10'(35 + 250);
      @(negedge clk); chk("pix_body", int'(ro[1]), 12'hCCC);
      vCount = 10'(35 + 220);
      @(negedge clk); chk("pix_win_edge", int'(ro[1]), 12'hCCC);
      hCount = 10'(144 + 10);
      @(negedge clk); chk("pix_bg", int'(ro[1]), int'(BG_RST));
      bright = 0;
      @(negedge clk); chk("pix_dark", int'(ro[1]), 0);
      repeat (4) @(negedge clk);

      right = 1;
      for (int k = 1; k <= 146; k++) begin
         @(negedge clk);
         if (k == 143) chk("wrap_x_574", int'(xo[1]), 574);
         if (k == 144) chk("wrap_x_576", int'(xo[1]), 576);
         if (k == 145) chk("wrap_x_0", int'(xo[1]), 0);
         if (k == 146) chk("wrap_x_2", int'(xo[1]), 2);
         if (k == 146) chk("clamp_x_576", int'(xo[2]), 576);
      end
      right = 0; left = 1;
      @(negedge clk); chk("left_x_0", int'(xo[1]), 0);
      @(negedge clk); chk("left_wrap_576", int'(xo[1]), 576);
      left = 0; up = 1;
      for (int k = 1; k <= 110; k++) begin
         @(negedge clk);
         if (k == 107) chk("clamp_y_2", int'(yo[2]), 2);
         if (k >= 108) chk("clamp_y_0", int'(yo[2]), 0);
         if (k == 109) chk("wrap_y_432", int'(yo[1]), 432);
      end
      up = 0; down = 1; right = 1;
      @(negedge clk);
      chk("prio_x", int'(xo[2]), 574);
      chk("prio_y", int'(yo[2]), 0);
      down = 0; right = 0; left = 1;
      @(negedge clk);
      left = 0; bright = 1; hCount = 10'(144 + 100); vCount = 10'(35 + 400);
      @(negedge clk); chk("bg_after_left", int'(ro[2]), int'(BG_LEFT));
      @(negedge clk); chk("bg_hold", int'(ro[2]), int'(BG_LEFT));

      bright = 0; shield_btn = 1;
      @(negedge clk); chk("pre_rst_shield", int'(so[1]), 1);
      shield_btn = 0; rst = 1;
      @(negedge clk);
      chk("rst_shield", int'(so[1]), 0);
      chk("rst_xpos", int'(xo[1]), 288);
      chk("rst_ypos", int'(yo[1]), 216);
      rst = 0;
      repeat (6) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
